// File: rtl/axi_lite_sram_if.sv
// AXI4-Lite bus bundle for axi_lite_sram: read (AR/R) and write (AW/W/B) channels.
// The slave modport is used by the memory; the master modport by whatever drives it.
interface axi_lite_sram_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) ();

   // Read address / read data channels
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   // Write address / write data / write response channels
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport slave (
      input  araddr, arvalid, rready,
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid,
      output awready, wready, bresp, bvalid
   );

   modport master (
      output araddr, arvalid, rready,
      output awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid,
      input  awready, wready, bresp, bvalid
   );

endinterface

// File: rtl/axi_lite_sram.sv
// axi_lite_sram: parametrised AXI4-Lite slave word memory with independent
// read and write engines, DECERR decode for out-of-range addresses and a
// per-access wait count. Optional macro SRAM_RAND_DELAY_EN replaces the fixed
// RD_LAT/WR_LAT waits with LFSR-derived random waits for bus-robustness runs.
module axi_lite_sram #(
   parameter int unsigned           DATA_W    = 32,
   parameter int unsigned           ADDR_W    = 32,
   parameter int unsigned           DEPTH     = 1024,
   parameter logic [ADDR_W-1:0]     BASE      = ADDR_W'(32'h8000_0000),
   parameter int unsigned           RD_LAT    = 1,
   parameter int unsigned           WR_LAT    = 0,
   parameter int unsigned           LFSR_SEED = 8'hA5,
   parameter int unsigned           RAND_MASK = 4'hF
) (
   input  logic                  clk,
   input  logic                  rst,
   axi_lite_sram_if.slave        bus
);

   localparam int unsigned NB     = DATA_W / 8;
   localparam int unsigned OFF_W  = $clog2(NB);
   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = 4;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_DECERR = 2'b11;

   // Reject parameter sets the datapath cannot honour
   if (!((DATA_W == 32) || (DATA_W == 64)) || (RD_LAT > 15) || (WR_LAT > 15) ||
       (LFSR_SEED == 0) || (LFSR_SEED > 255) || (RAND_MASK > 15) ||
       ((DEPTH & (DEPTH - 1)) != 0)) begin : g_param_chk
      $error("axi_lite_sram: illegal parameter set");
   end

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_e;
   typedef enum logic [1:0] {W_COLLECT, W_WAIT, W_RESP} wr_state_e;

   // Word storage; deliberately not reset
   logic [DATA_W-1:0] mem_q [DEPTH];

   // Read engine state
   rd_state_e         rstate_q;
   logic              arready_q;
   logic              rvalid_q;
   logic [DATA_W-1:0] rdata_q;
   logic [1:0]        rresp_q;
   logic [CNT_W-1:0]  rcnt_q;
   logic [ADDR_W-1:0] ar_addr_q;

   // Write engine state
   wr_state_e         wstate_q;
   logic              awready_q;
   logic              wready_q;
   logic              bvalid_q;
   logic [1:0]        bresp_q;
   logic [CNT_W-1:0]  wcnt_q;
   logic              aw_held_q;
   logic              w_held_q;
   logic [ADDR_W-1:0] aw_addr_q;
   logic [DATA_W-1:0] w_data_q;
   logic [NB-1:0]     w_strb_q;

   // Delay values loaded at request acceptance
   logic [CNT_W-1:0]  rd_delay_c;
   logic [CNT_W-1:0]  wr_delay_c;

`ifdef SRAM_RAND_DELAY_EN
   logic [7:0] lfsr_q;

   // Fibonacci LFSR x^8+x^6+x^5+x^4+1, free-running every cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= 8'(LFSR_SEED);
      end else begin
         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
   end

   assign rd_delay_c = lfsr_q[3:0] & CNT_W'(RAND_MASK);
   assign wr_delay_c = lfsr_q[7:4] & CNT_W'(RAND_MASK);
`else
   assign rd_delay_c = CNT_W'(RD_LAT);
   assign wr_delay_c = CNT_W'(WR_LAT);
`endif

   // Address decode: offset from BASE, word index and range flag per engine
   logic [ADDR_W-1:0] rd_off_c;
   logic [ADDR_W-1:0] wr_off_c;
   logic [IDX_W-1:0]  rd_idx_c;
   logic [IDX_W-1:0]  wr_idx_c;
   logic              rd_in_range_c;
   logic              wr_in_range_c;

   always_comb begin
      rd_off_c      = ar_addr_q - BASE;
      wr_off_c      = aw_addr_q - BASE;
      rd_idx_c      = IDX_W'(rd_off_c >> OFF_W);
      wr_idx_c      = IDX_W'(wr_off_c >> OFF_W);
      rd_in_range_c = (rd_off_c >> (OFF_W + IDX_W)) == '0;
      wr_in_range_c = (wr_off_c >> (OFF_W + IDX_W)) == '0;
   end

   // Handshake qualifiers for the write collect phase
   logic aw_hs_c;
   logic w_hs_c;
   logic aw_have_c;
   logic w_have_c;
   logic wr_commit_c;

   always_comb begin
      aw_hs_c     = awready_q & bus.awvalid;
      w_hs_c      = wready_q & bus.wvalid;
      aw_have_c   = aw_held_q | aw_hs_c;
      w_have_c    = w_held_q | w_hs_c;
      wr_commit_c = (wstate_q == W_WAIT) && (wcnt_q == '0) && wr_in_range_c;
   end

   // Read engine: accept AR, wait rcnt cycles, present and hold R until taken
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rstate_q  <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         rcnt_q    <= '0;
         ar_addr_q <= '0;
      end else begin
         case (rstate_q)
            R_IDLE: begin
               arready_q <= 1'b1;
               if (arready_q && bus.arvalid) begin
                  arready_q <= 1'b0;
                  ar_addr_q <= bus.araddr;
                  rcnt_q    <= rd_delay_c;
                  rstate_q  <= R_WAIT;
               end
            end
            R_WAIT: begin
               if (rcnt_q != '0) begin
                  rcnt_q <= rcnt_q - CNT_W'(1);
               end else begin
                  if (rd_in_range_c) begin
                     rdata_q <= mem_q[rd_idx_c];
                     rresp_q <= RESP_OKAY;
                  end else begin
                     rdata_q <= '0;
                     rresp_q <= RESP_DECERR;
                  end
                  rvalid_q <= 1'b1;
                  rstate_q <= R_RESP;
               end
            end
            R_RESP: begin
               if (bus.rready) begin
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
                  rstate_q  <= R_IDLE;
               end
            end
            default: begin
               rstate_q <= R_IDLE;
            end
         endcase
      end
   end

   // Write engine: collect AW and W in either order, wait wcnt cycles, respond on B
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wstate_q  <= W_COLLECT;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         wcnt_q    <= '0;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
      end else begin
         case (wstate_q)
            W_COLLECT: begin
               if (aw_hs_c) begin
                  aw_addr_q <= bus.awaddr;
                  aw_held_q <= 1'b1;
               end
               if (w_hs_c) begin
                  w_data_q <= bus.wdata;
                  w_strb_q <= bus.wstrb;
                  w_held_q <= 1'b1;
               end
               if (aw_have_c && w_have_c) begin
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  wcnt_q    <= wr_delay_c;
                  wstate_q  <= W_WAIT;
               end else begin
                  awready_q <= !aw_have_c;
                  wready_q  <= !w_have_c;
               end
            end
            W_WAIT: begin
               if (wcnt_q != '0) begin
                  wcnt_q <= wcnt_q - CNT_W'(1);
               end else begin
                  bresp_q  <= wr_in_range_c ? RESP_OKAY : RESP_DECERR;
                  bvalid_q <= 1'b1;
                  wstate_q <= W_RESP;
               end
            end
            W_RESP: begin
               if (bus.bready) begin
                  bvalid_q  <= 1'b0;
                  aw_held_q <= 1'b0;
                  w_held_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
                  wstate_q  <= W_COLLECT;
               end
            end
            default: begin
               wstate_q <= W_COLLECT;
            end
         endcase
      end
   end

   // Byte-masked commit; a same-edge read sees the pre-write word
   always_ff @(posedge clk) begin
      if (wr_commit_c) begin
         for (int b = 0; b < int'(NB); b++) begin
            if (w_strb_q[b]) begin
               mem_q[wr_idx_c][b*8 +: 8] <= w_data_q[b*8 +: 8];
            end
         end
      end
   end

   assign bus.arready = arready_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.rdata   = rdata_q;
   assign bus.rresp   = rresp_q;
   assign bus.awready = awready_q;
   assign bus.wready  = wready_q;
   assign bus.bvalid  = bvalid_q;
   assign bus.bresp   = bresp_q;

endmodule

// File: tb/tb_axi_lite_sram.sv
// Bench for axi_lite_sram: directed scenarios plus randomized traffic checked
// against a flat word-array model of the memory map.
module tb_axi_lite_sram;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned DEPTH     = 1024;
   localparam int unsigned RD_LAT    = 1;
   localparam int unsigned WR_LAT    = 0;
   localparam int unsigned RAND_MASK = 15;
   localparam logic [31:0] BASE      = 32'h8000_0000;
   localparam longint unsigned SPAN  = longint'(DEPTH) * 4;
`ifdef SRAM_RAND_DELAY_EN
   localparam int N_RAND = 1000;
`else
   localparam int N_RAND = 200;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi_lite_sram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   axi_lite_sram #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE),
      .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .LFSR_SEED(8'hA5), .RAND_MASK(RAND_MASK)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] model [DEPTH];

   function automatic bit in_rng(logic [31:0] a);
      longint unsigned x = longint'(a);
      return (x >= longint'(BASE)) && (x < longint'(BASE) + SPAN);
   endfunction

   function automatic int widx(logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   function automatic void model_write(logic [31:0] a, logic [31:0] d, logic [3:0] s);
      if (in_rng(a)) begin
         for (int b = 0; b < 4; b++) begin
            if (s[b]) model[widx(a)][b*8 +: 8] = d[b*8 +: 8];
         end
      end
   endfunction

   function automatic logic [31:0] exp_rdata(logic [31:0] a);
      return in_rng(a) ? model[widx(a)] : 32'h0;
   endfunction

   function automatic logic [1:0] exp_resp(logic [31:0] a);
      return in_rng(a) ? 2'b00 : 2'b11;
   endfunction

   // Cycles from handshake edge to valid is wait count + 1
   function automatic bit lat_ok(int lat, int fixed);
`ifdef SRAM_RAND_DELAY_EN
      return (lat >= 1) && (lat <= int'(RAND_MASK) + 1) && (fixed >= 0);
`else
      return lat == fixed + 1;
`endif
   endfunction

   function automatic logic [31:0] rand_in_addr();
      return BASE + 32'($urandom_range(0, int'(SPAN) - 1));
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] r, output int lat);
      int n = 0;
      bus.araddr  = a;
      bus.arvalid = 1'b1;
      while (bus.arready !== 1'b1 && n < 50) begin step(); n++; end
      step();
      bus.arvalid = 1'b0;
      lat = 0;
      while (bus.rvalid !== 1'b1 && lat < 50) begin step(); lat++; end
      if (n >= 50 || lat >= 50) begin
         n_checks++;
         $display("FAIL read_timeout: addr %h arready_wait %0d rvalid_wait %0d limit 50", a, n, lat);
      end
      d = bus.rdata;
      r = bus.rresp;
      bus.rready = 1'b1;
      step();
      bus.rready = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r, output int lat);
      int n = 0;
      bus.awaddr  = a;
      bus.awvalid = 1'b1;
      bus.wdata   = d;
      bus.wstrb   = s;
      bus.wvalid  = 1'b1;
      while (!(bus.awready === 1'b1 && bus.wready === 1'b1) && n < 50) begin step(); n++; end
      step();
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      lat = 0;
      while (bus.bvalid !== 1'b1 && lat < 50) begin step(); lat++; end
      if (n >= 50 || lat >= 50) begin
         n_checks++;
         $display("FAIL write_timeout: addr %h ready_wait %0d bvalid_wait %0d limit 50", a, n, lat);
      end
      r = bus.bresp;
      bus.bready = 1'b1;
      step();
      bus.bready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_checks++;
      if ({bus.arready, bus.awready, bus.wready} !== 3'b000)
         $display("FAIL reset_readies: got %b expected 000", {bus.arready, bus.awready, bus.wready});
      else n_pass++;
      n_checks++;
      if ({bus.rvalid, bus.bvalid} !== 2'b00)
         $display("FAIL reset_valids: got %b expected 00", {bus.rvalid, bus.bvalid});
      else n_pass++;
      n_checks++;
      if ({bus.rdata, bus.rresp, bus.bresp} !== 36'h0)
         $display("FAIL reset_data_resp: got %h expected 0", {bus.rdata, bus.rresp, bus.bresp});
      else n_pass++;
      rst = 1'b0;
      #1;
      n_checks++;
      if (bus.arready !== 1'b0)
         $display("FAIL reset_release_pre_edge: arready %b expected 0", bus.arready);
      else n_pass++;
      step();
      n_checks++;
      if ({bus.arready, bus.awready, bus.wready} !== 3'b111)
         $display("FAIL reset_release_readies: got %b expected 111", {bus.arready, bus.awready, bus.wready});
      else n_pass++;
   endtask

   task automatic test_fill();
      logic [1:0] r;
      int lat;
      logic [31:0] d;
      for (int i = 0; i < int'(DEPTH); i++) begin
         d = $urandom;
         do_write(BASE + 32'(i * 4), d, 4'hF, r, lat);
         model_write(BASE + 32'(i * 4), d, 4'hF);
         n_checks++;
         if (r !== 2'b00) $display("FAIL fill_bresp: word %0d got %b expected 00", i, r);
         else n_pass++;
      end
   endtask

   task automatic test_basic();
      logic [1:0] r;
      logic [31:0] d;
      int lat;
      do_write(32'h8000_0010, 32'hDEADBEEF, 4'hF, r, lat);
      model_write(32'h8000_0010, 32'hDEADBEEF, 4'hF);
      n_checks++;
      if (!lat_ok(lat, int'(WR_LAT)) || r !== 2'b00)
         $display("FAIL basic_write: lat %0d bresp %b expected lat %0d bresp 00", lat, r, WR_LAT + 1);
      else n_pass++;
      do_read(32'h8000_0010, d, r, lat);
      n_checks++;
      if (!lat_ok(lat, int'(RD_LAT)))
         $display("FAIL basic_read_lat: got %0d expected %0d", lat, RD_LAT + 1);
      else n_pass++;
      n_checks++;
      if (d !== 32'hDEADBEEF || r !== 2'b00)
         $display("FAIL basic_read_data: got %h/%b expected deadbeef/00", d, r);
      else n_pass++;
   endtask

   task automatic test_strobe();
      logic [1:0] r;
      logic [31:0] d;
      int lat;
      logic [31:0] a = rand_in_addr();
      do_write(a, 32'hAABBCCDD, 4'hF, r, lat);
      model_write(a, 32'hAABBCCDD, 4'hF);
      do_write(a, 32'h11223344, 4'b0101, r, lat);
      model_write(a, 32'h11223344, 4'b0101);
      do_read(a, d, r, lat);
      n_checks++;
      if (d !== 32'hAA22CC44 || r !== 2'b00)
         $display("FAIL strobe_merge: got %h/%b expected aa22cc44/00", d, r);
      else n_pass++;
   endtask

   task automatic test_w_first();
      logic [1:0] r;
      logic [31:0] d;
      int lat;
      int n = 0;
      logic [31:0] a = rand_in_addr();
      logic [31:0] wd = $urandom;
      bus.wdata  = wd;
      bus.wstrb  = 4'hF;
      bus.wvalid = 1'b1;
      while (bus.wready !== 1'b1 && n < 50) begin step(); n++; end
      step();
      bus.wvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (bus.wready !== 1'b0 || bus.awready !== 1'b1 || bus.bvalid !== 1'b0)
            $display("FAIL wfirst_hold: cycle %0d wready/awready/bvalid %b%b%b expected 010",
                     i, bus.wready, bus.awready, bus.bvalid);
         else n_pass++;
         step();
      end
      bus.awaddr  = a;
      bus.awvalid = 1'b1;
      n_checks++;
      if (bus.awready !== 1'b1 || bus.wready !== 1'b0)
         $display("FAIL wfirst_aw_ready: awready/wready %b%b expected 10", bus.awready, bus.wready);
      else n_pass++;
      step();
      bus.awvalid = 1'b0;
      lat = 0;
      while (bus.bvalid !== 1'b1 && lat < 50) begin step(); lat++; end
      n_checks++;
      if (!lat_ok(lat, int'(WR_LAT)) || bus.bresp !== 2'b00 || bus.wready !== 1'b0)
         $display("FAIL wfirst_b: lat %0d bresp %b wready %b expected lat %0d bresp 00 wready 0",
                  lat, bus.bresp, bus.wready, WR_LAT + 1);
      else n_pass++;
      bus.bready = 1'b1;
      step();
      bus.bready = 1'b0;
      model_write(a, wd, 4'hF);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (bus.bvalid !== 1'b0 || bus.wready !== 1'b1)
            $display("FAIL wfirst_single_b: cycle %0d bvalid/wready %b%b expected 01",
                     i, bus.bvalid, bus.wready);
         else n_pass++;
         step();
      end
      do_read(a, d, r, lat);
      n_checks++;
      if (d !== exp_rdata(a)) $display("FAIL wfirst_data: got %h expected %h", d, exp_rdata(a));
      else n_pass++;
   endtask

   task automatic test_decerr();
      logic [1:0] r;
      logic [31:0] d;
      int lat;
      logic [31:0] probes [4];
      probes[0] = 32'h0000_0000;
      probes[1] = BASE - 32'd4;
      probes[2] = BASE + 32'(SPAN);
      probes[3] = BASE + 32'(SPAN) - 32'd4;
      for (int i = 0; i < 4; i++) begin
         do_read(probes[i], d, r, lat);
         n_checks++;
         if (d !== exp_rdata(probes[i]) || r !== exp_resp(probes[i]))
            $display("FAIL decerr_read: addr %h got %h/%b expected %h/%b",
                     probes[i], d, r, exp_rdata(probes[i]), exp_resp(probes[i]));
         else n_pass++;
      end
      do_write(32'h9000_0000, $urandom, 4'hF, r, lat);
      n_checks++;
      if (r !== 2'b11) $display("FAIL decerr_write: got %b expected 11", r);
      else n_pass++;
      do_write(BASE + 32'(SPAN), $urandom, 4'hF, r, lat);
      n_checks++;
      if (r !== 2'b11) $display("FAIL decerr_write_top: got %b expected 11", r);
      else n_pass++;
      for (int i = 0; i < int'(DEPTH); i++) begin
         do_read(BASE + 32'(i * 4), d, r, lat);
         n_checks++;
         if (d !== model[i] || r !== 2'b00)
            $display("FAIL decerr_scan: word %0d got %h/%b expected %h/00", i, d, r, model[i]);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      logic [1:0] r;
      logic [31:0] d;
      int lat;
      int n = 0;
      logic [31:0] a = rand_in_addr();
      logic [31:0] e = exp_rdata(a);
      bus.araddr  = a;
      bus.arvalid = 1'b1;
      while (bus.arready !== 1'b1 && n < 50) begin step(); n++; end
      step();
      bus.araddr = a ^ 32'h40;
      lat = 0;
      while (bus.rvalid !== 1'b1 && lat < 50) begin step(); lat++; end
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (bus.rvalid !== 1'b1 || bus.rdata !== e || bus.arready !== 1'b0)
            $display("FAIL bp_hold: cycle %0d rvalid %b rdata %h arready %b expected 1 %h 0",
                     i, bus.rvalid, bus.rdata, bus.arready, e);
         else n_pass++;
         step();
      end
      bus.arvalid = 1'b0;
      bus.rready  = 1'b1;
      step();
      bus.rready = 1'b0;
      n_checks++;
      if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1)
         $display("FAIL bp_release: rvalid/arready %b%b expected 01", bus.rvalid, bus.arready);
      else n_pass++;
      do_read(a, d, r, lat);
      n_checks++;
      if (d !== e) $display("FAIL bp_next_read: got %h expected %h", d, e);
      else n_pass++;
   endtask

`ifndef SRAM_RAND_DELAY_EN
   task automatic test_same_edge();
      logic [1:0] r;
      logic [31:0] d;
      int lat;
      logic [31:0] a   = BASE + 32'h200;
      logic [31:0] old = exp_rdata(a);
      logic [31:0] nd  = ~old;
      bus.araddr  = a;
      bus.arvalid = 1'b1;
      step();
      bus.arvalid = 1'b0;
      bus.awaddr  = a;
      bus.awvalid = 1'b1;
      bus.wdata   = nd;
      bus.wstrb   = 4'hF;
      bus.wvalid  = 1'b1;
      step();
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      step();
      n_checks++;
      if (bus.rvalid !== 1'b1 || bus.bvalid !== 1'b1 || bus.rdata !== old)
         $display("FAIL same_edge: rvalid %b bvalid %b rdata %h expected 1 1 %h",
                  bus.rvalid, bus.bvalid, bus.rdata, old);
      else n_pass++;
      model_write(a, nd, 4'hF);
      bus.rready = 1'b1;
      bus.bready = 1'b1;
      step();
      bus.rready = 1'b0;
      bus.bready = 1'b0;
      do_read(a, d, r, lat);
      n_checks++;
      if (d !== nd) $display("FAIL same_edge_after: got %h expected %h", d, nd);
      else n_pass++;
   endtask
`endif

   task automatic test_reset_mid();
      logic [1:0] r;
      logic [31:0] d;
      int lat;
      logic [31:0] a = BASE + 32'h100;
      do_write(a, 32'h5A5A_1234, 4'hF, r, lat);
      model_write(a, 32'h5A5A_1234, 4'hF);
      bus.awaddr = a;
      bus.wdata  = 32'hFFFF_FFFF;
      bus.wstrb  = 4'hF;
      bus.wvalid = 1'b1;
      step();
      bus.wvalid  = 1'b0;
      bus.araddr  = a;
      bus.arvalid = 1'b1;
      step();
      bus.arvalid = 1'b0;
      n_checks++;
      if (bus.rvalid !== 1'b0 || bus.awready !== 1'b1)
         $display("FAIL rstmid_pre: rvalid/awready %b%b expected 01", bus.rvalid, bus.awready);
      else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.rvalid, bus.arready, bus.awready, bus.wready, bus.bvalid} !== 5'b0)
         $display("FAIL rstmid_async: rvalid/arready/awready/wready/bvalid %b expected 00000",
                  {bus.rvalid, bus.arready, bus.awready, bus.wready, bus.bvalid});
      else n_pass++;
      step();
      rst = 1'b0;
      step();
      n_checks++;
      if ({bus.arready, bus.awready, bus.wready} !== 3'b111)
         $display("FAIL rstmid_release: readies %b expected 111", {bus.arready, bus.awready, bus.wready});
      else n_pass++;
      do_read(a, d, r, lat);
      n_checks++;
      if (d !== 32'h5A5A_1234 || r !== 2'b00)
         $display("FAIL rstmid_data: got %h/%b expected 5a5a1234/00", d, r);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [1:0] r;
      logic [31:0] d;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0] s;
      int lat;
      for (int i = 0; i < N_RAND; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            a = $urandom;
            while (in_rng(a)) a = $urandom;
         end else begin
            a = rand_in_addr();
         end
         if ($urandom_range(0, 1) == 0) begin
            do_read(a, d, r, lat);
            n_checks++;
            if (d !== exp_rdata(a) || r !== exp_resp(a) || !lat_ok(lat, int'(RD_LAT)))
               $display("FAIL rand_read: op %0d addr %h got %h/%b lat %0d expected %h/%b",
                        i, a, d, r, lat, exp_rdata(a), exp_resp(a));
            else n_pass++;
         end else begin
            wd = $urandom;
            s  = 4'($urandom_range(0, 15));
            do_write(a, wd, s, r, lat);
            model_write(a, wd, s);
            n_checks++;
            if (r !== exp_resp(a) || !lat_ok(lat, int'(WR_LAT)))
               $display("FAIL rand_write: op %0d addr %h bresp %b lat %0d expected %b",
                        i, a, r, lat, exp_resp(a));
            else n_pass++;
         end
      end
   endtask

   initial begin
      bus.araddr  = '0;
      bus.arvalid = 1'b0;
      bus.rready  = 1'b0;
      bus.awaddr  = '0;
      bus.awvalid = 1'b0;
      bus.wdata   = '0;
      bus.wstrb   = '0;
      bus.wvalid  = 1'b0;
      bus.bready  = 1'b0;
      test_reset();
      test_fill();
      test_basic();
      test_strobe();
      test_w_first();
      test_decerr();
      test_backpressure();
`ifndef SRAM_RAND_DELAY_EN
      test_same_edge();
`endif
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_checks);
      $fatal(1, "simulation time limit");
   end

endmodule

// File: doc/axi_lite_sram.md
# axi_lite_sram

Parametrised AXI4-Lite slave memory that replaces the fixed 32-bit DPI-backed SRAM model in the NPC memory subsystem. It has configurable data width, depth and base address, and holds an internal word array. Read and write channels are fully independent. AW and W can arrive in any order. Out-of-range accesses are decoded to error responses. Per-access latency is either fixed by parameter or drawn from an LFSR for bus-robustness testing.

## Interface
- DATA_W, 32, data width in bits; multiple of 8, 32 or 64.
- ADDR_W, 32, address width.
- DEPTH, 1024, number of DATA_W words; power of 2.
- BASE, 32'h8000_0000, byte base address; aligned to DEPTH*DATA_W/8.
- RD_LAT, 1, fixed read wait cycles, 0..15.
- WR_LAT, 0, fixed write wait cycles, 0..15.
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero.
- RAND_MASK, 4'hF, mask applied to random delays.
- clk  in  1  clock.
- rst  in  1  reset; **asynchronous, active-high**.
- araddr  in  ADDR_W  read address.
- arvalid  in  1; arready  out  1.
- rdata  out  DATA_W  read data.
- rresp  out  2  read response: 2'b00 OKAY, 2'b11 DECERR.
- rvalid  out  1; rready  in  1.
- awaddr  in  ADDR_W  write address.
- awvalid  in  1; awready  out  1.
- wdata  in  DATA_W; wstrb  in  DATA_W/8  byte enables.
- wvalid  in  1; wready  out  1.
- bresp  out  2  write response, same encoding as rresp.
- bvalid  out  1; bready  in  1.

## Operation
- Word index = (addr − BASE) >> log2(DATA_W/8). Address low bits are ignored.
- An address is in range iff BASE ≤ addr < BASE + DEPTH*DATA_W/8.
- Read FSM has three states:
  - R_IDLE: arready=1. On AR handshake, latch the address, load rcnt with the read delay, go to R_WAIT.
  - R_WAIT: decrement rcnt while it is nonzero. When rcnt==0, sample the array (or 0 with DECERR if out of range) into rdata/rresp and go to R_RESP. A delay of 0 passes through R_WAIT for exactly one cycle.
  - R_RESP: rvalid=1. rdata/rresp are held stable until the R handshake, then return to R_IDLE.
- Write FSM has three states:
  - W_COLLECT: awready=!aw_held and wready=!w_held. Each channel latches independently. The state moves once both are held, including when both handshakes occur in the same cycle. Loads wcnt with the write delay.
  - W_WAIT: count down as for reads. At wcnt==0, commit bytes where wstrb=1 (in range only; out of range leaves memory untouched and sets bresp=DECERR), then go to W_RESP.
  - W_RESP: bvalid=1 until the B handshake, then return to W_COLLECT and clear both held flags.
- There is at most one outstanding read and one outstanding write.
- Read and write commit on the same edge to the same word: the read returns the pre-write data.
- Memory contents are not reset.

## Timing
- Reset values: arready=awready=wready=0 while rst is high, and 1 from the first edge after release. rvalid=bvalid=0, rdata=0, rresp=bresp=2'b00, both FSMs idle, rcnt=wcnt=0, LFSR=LFSR_SEED.
- Read latency: AR handshake at edge N gives rvalid high after edge N+1+delay.
- Write latency: the later of AW/W handshakes at edge N gives bvalid high after edge N+1+delay.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Back-pressure (rready/bready low) holds the response indefinitely. No new request of that type is accepted meanwhile.
- Reset asserted mid-transaction: outputs go to reset values immediately (async) and the in-flight transaction is discarded. A committed write remains in memory; an uncommitted write is lost.

## Configuration
- SRAM_RAND_DELAY_EN defined:
  - An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) advances every cycle.
  - Read delay = lfsr[3:0] & RAND_MASK, sampled at the AR handshake.
  - Write delay = lfsr[7:4] & RAND_MASK, sampled at the completing handshake.
  - RD_LAT and WR_LAT are ignored.
- SRAM_RAND_DELAY_EN undefined: no LFSR is instantiated. Delays are RD_LAT and WR_LAT exactly.

## Test plan
All scenarios use defaults and the macro undefined unless stated.
- Write 32'hDEADBEEF to 32'h8000_0010 with wstrb=4'hF, AW and W in the same cycle:
  - bvalid on the next cycle, bresp=00.
  - Read of the same address: rvalid 2 cycles after the AR handshake, rdata=32'hDEADBEEF, rresp=00.
- Preload 32'hAABBCCDD, then write 32'h11223344 with wstrb=4'b0101: readback is 32'hAA22CC44.
- W handshakes 3 cycles before AW:
  - wready is low from the cycle after the W handshake until B completes.
  - Exactly one bvalid pulse, data committed correctly.
- Read 32'h0000_0000: rresp=2'b11, rdata=0. Write to 32'h9000_0000: bresp=2'b11, and a readback of every word is unchanged.
- rready held low 5 cycles after rvalid: rvalid and rdata stay stable and arready stays 0. The handshake on cycle 6 returns the FSM to idle.
- rst pulsed during R_WAIT with RD_LAT=5:
  - rvalid=0 and arready=0 immediately.
  - arready=1 after release.
  - Previously written data still reads back.
  - With SRAM_RAND_DELAY_EN, 1000 random reads and writes complete with correct data, and every delay is ≤ RAND_MASK.
